// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: arbitrates trap, memory-wait,
// taken-branch and load-use events. Optional perf counters under HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic        mem_busy,
    input  logic        branch_taken_ex,
    input  logic        load_use_hazard,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic [1:0]  redirect_sel,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        busy_flush
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(IMEM_LAT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        redirect     = 1'b0;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        redirect_sel = 2'b00;
        busy_flush   = 1'b0;

        if (state == FLUSH) begin
            busy_flush  = 1'b1;
            flush_if_id = 1'b1;
        end

        // Trap/branch stay asserted while EX is frozen, so mem_busy simply defers them.
        if (mem_busy) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
        end else if (trap_req) begin
            redirect     = 1'b1;
            redirect_sel = 2'b10;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (branch_taken_ex) begin
            redirect     = 1'b1;
            redirect_sel = 2'b01;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
        end else if (state == RUN && load_use_hazard) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            flush_id_ex = 1'b1;
        end else if (state == FLUSH) begin
            if (cnt <= ONE_CNT) begin
                state_next = RUN;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt - ONE_CNT;
            end
        end

        // A redirect (re)starts the kill window for fetches already in flight.
        if (redirect && IMEM_LAT > 0) begin
            state_next = FLUSH;
            cnt_next   = LAT_CNT;
        end

        if (!rst_n) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
            flush_ex_mem = 1'b0;
            redirect_sel = 2'b00;
            busy_flush   = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!pc_we && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_sel != 2'b00 && perf_flush_cnt != 32'hFFFF_FFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (IMEM_LAT=1 and 3) share
// stimulus; a monitor pops expected output vectors and compares each cycle.
module tb_pipeline_hazard_ctrl;

    // Vector order: pc, if_id, id_ex, ex_mem we; flush if_id, id_ex, ex_mem; redirect[1:0]; busy
    localparam logic [9:0] V_OFF   = 10'b0000_000_00_0;
    localparam logic [9:0] V_RUN   = 10'b1111_000_00_0;
    localparam logic [9:0] V_BR    = 10'b1111_110_01_0;
    localparam logic [9:0] V_TRAP  = 10'b1111_111_10_0;
    localparam logic [9:0] V_LU    = 10'b0011_010_00_0;
    localparam logic [9:0] V_FL    = 10'b1111_100_00_1;
    localparam logic [9:0] V_FL_MB = 10'b0000_100_00_1;
    localparam logic [9:0] V_BR_FL = 10'b1111_110_01_1;

    typedef struct {
        logic [9:0] exp1;
        logic [9:0] exp3;
        int         step;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n, trap_req, mem_busy, branch_taken_ex, load_use_hazard;

    logic       pc_we1, if_id_we1, id_ex_we1, ex_mem_we1, fl_if_id1, fl_id_ex1, fl_ex_mem1, busy1;
    logic [1:0] redir1;
    logic       pc_we3, if_id_we3, id_ex_we3, ex_mem_we3, fl_if_id3, fl_id_ex3, fl_ex_mem3, busy3;
    logic [1:0] redir3;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

    sb_t sb_q[$];
    int  errors = 0;
    int  checks = 0;
    int  step   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.IMEM_LAT(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .mem_busy(mem_busy),
        .branch_taken_ex(branch_taken_ex), .load_use_hazard(load_use_hazard),
        .pc_we(pc_we1), .if_id_we(if_id_we1), .id_ex_we(id_ex_we1), .ex_mem_we(ex_mem_we1),
        .flush_if_id(fl_if_id1), .flush_id_ex(fl_id_ex1), .flush_ex_mem(fl_ex_mem1),
        .redirect_sel(redir1),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(stall_cnt1), .perf_flush_cnt(flush_cnt1),
`endif
        .busy_flush(busy1)
    );

    pipeline_hazard_ctrl #(.IMEM_LAT(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .mem_busy(mem_busy),
        .branch_taken_ex(branch_taken_ex), .load_use_hazard(load_use_hazard),
        .pc_we(pc_we3), .if_id_we(if_id_we3), .id_ex_we(id_ex_we3), .ex_mem_we(ex_mem_we3),
        .flush_if_id(fl_if_id3), .flush_id_ex(fl_id_ex3), .flush_ex_mem(fl_ex_mem3),
        .redirect_sel(redir3),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(stall_cnt3), .perf_flush_cnt(flush_cnt3),
`endif
        .busy_flush(busy3)
    );

    task automatic checkOutput(input int s, input string name, input logic [9:0] got,
                               input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL step %0d %s: got %b expected %b", s, name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic tr, input logic mb,
                                 input logic br, input logic lu,
                                 input logic [9:0] e1, input logic [9:0] e3);
        sb_t e;
        @(negedge clk);
        rst_n           = rst;
        trap_req        = tr;
        mem_busy        = mb;
        branch_taken_ex = br;
        load_use_hazard = lu;
        e.exp1 = e1;
        e.exp3 = e3;
        e.step = step;
        sb_q.push_back(e);
        step++;
    endtask

    // Monitor: outputs are combinational, so sample mid-low-phase after stimulus settles.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput(e.step, "lat1",
                    {pc_we1, if_id_we1, id_ex_we1, ex_mem_we1, fl_if_id1, fl_id_ex1, fl_ex_mem1, redir1, busy1},
                    e.exp1);
                checkOutput(e.step, "lat3",
                    {pc_we3, if_id_we3, id_ex_we3, ex_mem_we3, fl_if_id3, fl_id_ex3, fl_ex_mem3, redir3, busy3},
                    e.exp3);
            end
        end
    end

    initial begin
        rst_n = 1'b0; trap_req = 1'b0; mem_busy = 1'b0; branch_taken_ex = 1'b0; load_use_hazard = 1'b0;

        // Reset, then idle run
        applyStimulus(0, 0, 0, 0, 0, V_OFF, V_OFF);
        applyStimulus(0, 0, 0, 0, 0, V_OFF, V_OFF);
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_RUN);
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_RUN);

        // Taken branch: one FLUSH cycle at latency 1, three at latency 3
        applyStimulus(1, 0, 0, 1, 0, V_BR,  V_BR);
        applyStimulus(1, 0, 0, 0, 0, V_FL,  V_FL);
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_FL);
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_FL);
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_RUN);

        // Load-use bubble
        applyStimulus(1, 0, 0, 0, 1, V_LU,  V_LU);
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_RUN);

        // mem_busy defers a pending branch, then freezes the FLUSH countdown
        applyStimulus(1, 0, 1, 1, 0, V_OFF, V_OFF);
        applyStimulus(1, 0, 1, 1, 0, V_OFF, V_OFF);
        applyStimulus(1, 0, 1, 1, 0, V_OFF, V_OFF);
        applyStimulus(1, 0, 0, 1, 0, V_BR,  V_BR);
        applyStimulus(1, 0, 0, 0, 0, V_FL,  V_FL);
        applyStimulus(1, 0, 1, 0, 0, V_OFF, V_FL_MB);
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_FL);
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_FL);
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_RUN);

        // Trap wins over branch and load-use; branch in FLUSH restarts; load-use ignored in FLUSH
        applyStimulus(1, 1, 0, 1, 1, V_TRAP,  V_TRAP);
        applyStimulus(1, 0, 0, 1, 0, V_BR_FL, V_BR_FL);
        applyStimulus(1, 0, 0, 0, 0, V_FL,    V_FL);
        applyStimulus(1, 0, 0, 0, 1, V_LU,    V_FL);
        applyStimulus(1, 0, 0, 0, 0, V_RUN,   V_FL);
        applyStimulus(1, 0, 0, 0, 0, V_RUN,   V_RUN);

        // Reset asserted mid-FLUSH (latency 3 at cnt=2)
        applyStimulus(1, 1, 0, 0, 0, V_TRAP, V_TRAP);
        applyStimulus(1, 0, 0, 0, 0, V_FL,   V_FL);
        applyStimulus(0, 0, 0, 0, 0, V_OFF,  V_OFF);
        applyStimulus(0, 0, 0, 0, 0, V_OFF,  V_OFF);
        applyStimulus(1, 0, 0, 0, 0, V_RUN,  V_RUN);
`ifdef HAZARD_PERF_EN
        #3;
        checks++;
        if ({stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3} !== 128'd0) begin
            errors++;
            $display("[TB] FAIL perf_after_reset: got %h %h %h %h expected all 0",
                     stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3);
        end
`endif
        applyStimulus(1, 0, 0, 0, 0, V_RUN, V_RUN);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        #3;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
